// File: rtl/moving_average_normalizer.sv
// Divides a signed windowed sum by SIZE, rounding half away from zero and saturating to WIDTH bits.
// Latency SUM_WIDTH+2 cycles, one sample per cycle. A global stall holds every stage while the output waits.
module moving_average_normalizer #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 6,
    localparam int SUM_WIDTH = WIDTH + $clog2(SIZE + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic signed [SUM_WIDTH-1:0] i_tdata,
    input  logic                        i_tvalid,
    output logic                        i_tready,
    output logic signed [WIDTH-1:0]     o_tdata,
    output logic                        o_tvalid,
    input  logic                        o_tready
);

    localparam int REM_W = $clog2(SIZE + 1);
    localparam logic [REM_W:0]     DIVISOR = (REM_W + 1)'(SIZE);
    localparam logic [SUM_WIDTH:0] POS_MAX = (SUM_WIDTH + 1)'((1 << (WIDTH - 1)) - 1);
    localparam logic [SUM_WIDTH:0] NEG_MAG = (SUM_WIDTH + 1)'(1 << (WIDTH - 1));

    logic adv;

    // Stage 0 holds sign/magnitude; stages 1..SUM_WIDTH each retire one quotient bit.
    logic                 vld [0:SUM_WIDTH];
    logic                 sgn [0:SUM_WIDTH];
    logic [REM_W-1:0]     rem [0:SUM_WIDTH];
    // Dividend bits shift out of the top while quotient bits shift in at the bottom.
    logic [SUM_WIDTH-1:0] dq  [0:SUM_WIDTH];

    logic [REM_W:0]       trial   [1:SUM_WIDTH];
    logic [REM_W-1:0]     rem_nxt [1:SUM_WIDTH];
    logic                 qbit    [1:SUM_WIDTH];

    logic                 round_up;
    logic [SUM_WIDTH:0]   q_round;
    logic [WIDTH-1:0]     result;

    assign adv      = !o_tvalid || o_tready;
    assign i_tready = rst && adv;

    always_comb begin
        for (int k = 1; k <= SUM_WIDTH; k++) begin
            trial[k]   = '0;
            rem_nxt[k] = '0;
            qbit[k]    = 1'b0;
        end
        for (int k = 1; k <= SUM_WIDTH; k++) begin
            trial[k] = {rem[k-1], dq[k-1][SUM_WIDTH-1]};
            if (trial[k] >= DIVISOR) begin
                rem_nxt[k] = REM_W'(trial[k] - DIVISOR);
                qbit[k]    = 1'b1;
            end else begin
                rem_nxt[k] = trial[k][REM_W-1:0];
                qbit[k]    = 1'b0;
            end
        end
    end

    always_comb begin
        round_up = 1'b0;
        q_round  = '0;
        result   = '0;
        round_up = {rem[SUM_WIDTH], 1'b0} >= DIVISOR;
        q_round  = {1'b0, dq[SUM_WIDTH]} + {{SUM_WIDTH{1'b0}}, round_up};
        if (sgn[SUM_WIDTH]) begin
            if (q_round >= NEG_MAG) begin
                result = {1'b1, {(WIDTH - 1){1'b0}}};
            end else begin
                result = -q_round[WIDTH-1:0];
            end
        end else begin
            if (q_round > POS_MAX) begin
                result = {1'b0, {(WIDTH - 1){1'b1}}};
            end else begin
                result = q_round[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k <= SUM_WIDTH; k++) begin
                vld[k] <= 1'b0;
            end
            o_tvalid <= 1'b0;
            o_tdata  <= '0;
        end else if (clear) begin
            for (int k = 0; k <= SUM_WIDTH; k++) begin
                vld[k] <= 1'b0;
            end
            o_tvalid <= 1'b0;
        end else if (adv) begin
            vld[0] <= i_tvalid;
            for (int k = 1; k <= SUM_WIDTH; k++) begin
                vld[k] <= vld[k-1];
            end
            o_tvalid <= vld[SUM_WIDTH];
            if (vld[SUM_WIDTH]) begin
                o_tdata <= result;
            end
        end
    end

    // Datapath carries no reset; only the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (adv) begin
            sgn[0] <= i_tdata[SUM_WIDTH-1];
            rem[0] <= '0;
            dq[0]  <= i_tdata[SUM_WIDTH-1] ? -i_tdata : i_tdata;
            for (int k = 1; k <= SUM_WIDTH; k++) begin
                sgn[k] <= sgn[k-1];
                rem[k] <= rem_nxt[k];
                dq[k]  <= {dq[k-1][SUM_WIDTH-2:0], qbit[k]};
            end
        end
    end

endmodule

// File: tb/tb_moving_average_normalizer.sv
// Scoreboard bench for moving_average_normalizer: directed vectors, ramp stream, backpressure, clear and reset.
module tb_moving_average_normalizer;

    localparam int WIDTH     = 8;
    localparam int SIZE      = 6;
    localparam int SUM_WIDTH = 11;
    localparam int LAT       = 13;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        clear;
    logic signed [SUM_WIDTH-1:0] i_tdata;
    logic                        i_tvalid;
    logic                        i_tready;
    logic signed [WIDTH-1:0]     o_tdata;
    logic                        o_tvalid;
    logic                        o_tready = 1'b1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_q[$];

    bit  bp_en      = 1'b0;
    bit  rdy_force  = 1'b1;
    int  flush_cnt  = 0;
    int  seen_flush = 0;
    bit  was_stalled = 1'b0;
    logic signed [WIDTH-1:0] held;
    logic exp_rdy;
    int   e;

    moving_average_normalizer #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .i_tdata  (i_tdata),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .o_tdata  (o_tdata),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // In-flight samples are discarded by reset or clear.
    always @(posedge clk) begin
        if (rst !== 1'b1 || clear === 1'b1) begin
            exp_q.delete();
            flush_cnt = flush_cnt + 1;
        end
    end

    always @(posedge clk) begin
        #2;
        o_tready = bp_en ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    function automatic int ref_avg(input int s);
        int m, q, r, res;
        m = (s < 0) ? -s : s;
        q = m / SIZE;
        r = m % SIZE;
        if (2 * r >= SIZE) q = q + 1;
        res = (s < 0) ? -q : q;
        if (res > 2**(WIDTH-1) - 1) res = 2**(WIDTH-1) - 1;
        if (res < -(2**(WIDTH-1))) res = -(2**(WIDTH-1));
        return res;
    endfunction

    always @(negedge clk) begin
        exp_rdy = rst && (!o_tvalid || o_tready);
        checks++;
        if (i_tready !== exp_rdy) begin
            failures++;
            $display("FAIL i_tready: got %b want %b at cycle %0d", i_tready, exp_rdy, cyc);
        end
        if (was_stalled && seen_flush == flush_cnt) begin
            checks++;
            if (o_tvalid !== 1'b1 || o_tdata !== held) begin
                failures++;
                $display("FAIL stall_hold: got vld=%b data=%0d want vld=1 data=%0d at cycle %0d",
                         o_tvalid, o_tdata, held, cyc);
            end
        end
        seen_flush = flush_cnt;
        if (o_tvalid === 1'b1 && o_tready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output: got %0d with nothing expected at cycle %0d", o_tdata, cyc);
            end else begin
                e = exp_q.pop_front();
                if (int'(o_tdata) != e) begin
                    failures++;
                    $display("FAIL data: got %0d want %0d at cycle %0d", o_tdata, e, cyc);
                end
            end
        end
        was_stalled = (o_tvalid === 1'b1) && (o_tready === 1'b0);
        held = o_tdata;
    end

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic drive_one(input int v, input int ev, output int acc_c);
        int n;
        n = 0;
        i_tvalid = 1'b1;
        i_tdata  = SUM_WIDTH'(v);
        @(negedge clk);
        while (i_tready !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (i_tready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: input %0d not accepted, i_tready=%b want 1", v, i_tready);
            acc_c = -1000;
        end else begin
            exp_q.push_back(ev);
            acc_c = cyc;
        end
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
    endtask

    task automatic wait_out(input int acc_c, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (o_tvalid !== 1'b1 && n < 60) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (o_tvalid !== 1'b1 || cyc - acc_c != LAT) begin
            failures++;
            $display("FAIL latency_%s: got %0d cycles (vld=%b) want %0d", name, cyc - acc_c, o_tvalid, LAT);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_%s: got %0d outstanding want 0", name, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name, input bit check_data);
        checks++;
        if (o_tvalid !== 1'b0 || (check_data && o_tdata !== '0)) begin
            failures++;
            $display("FAIL %s: got vld=%b data=%0d want vld=0%s", name, o_tvalid, o_tdata,
                     check_data ? " data=0" : "");
        end
    endtask

    initial begin
        int a;
        int first;
        int rv[6];
        int re[6];
        rv = '{9, -9, 8, -8, 3, -3};
        re = '{2, -2, 1, -1, 1, -1};

        rst = 1'b0; clear = 1'b0; i_tvalid = 1'b0; i_tdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset_state", 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        drive_one(762, 127, a);   wait_out(a, "pos_extreme");
        drive_one(-768, -128, a); wait_out(a, "neg_extreme");
        for (int i = 0; i < 6; i++) begin
            drive_one(rv[i], re[i], a);
            wait_out(a, "rounding");
        end
        drive_one(1023, 127, a);   wait_out(a, "sat_pos");
        drive_one(-1024, -128, a); wait_out(a, "sat_neg");
        drain("directed");

        // Continuous ramp with the consumer always ready: one output per cycle after the fill.
        first = 0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    drive_one(-768 + 4 * i, ref_avg(-768 + 4 * i), a);
                    if (i == 0) first = a;
                end
            end
            begin
                int n, gaps;
                n = 0; gaps = 0;
                @(negedge clk);
                while (o_tvalid !== 1'b1 && n < 200) begin
                    n++;
                    @(negedge clk);
                end
                checks++;
                if (o_tvalid !== 1'b1 || cyc - first != LAT) begin
                    failures++;
                    $display("FAIL stream_fill: got %0d cycles want %0d", cyc - first, LAT);
                end
                for (int j = 1; j < 400; j++) begin
                    @(negedge clk);
                    if (o_tvalid !== 1'b1) gaps++;
                end
                checks++;
                if (gaps != 0) begin
                    failures++;
                    $display("FAIL stream_gaps: got %0d bubbles want 0", gaps);
                end
            end
        join
        drain("stream");

        bp_en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            drive_one(-1024 + 13 * i, ref_avg(-1024 + 13 * i), a);
        end
        drain("backpressure");
        bp_en = 1'b0;
        rdy_force = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Flush with five samples in flight; the input offered alongside clear must be dropped.
        for (int i = 0; i < 5; i++) begin
            drive_one(100 + 6 * i, ref_avg(100 + 6 * i), a);
        end
        clear = 1'b1; i_tvalid = 1'b1; i_tdata = SUM_WIDTH'(600);
        @(posedge clk);
        #1;
        clear = 1'b0; i_tvalid = 1'b0;
        @(negedge clk);
        check_idle("after_clear", 1'b0);
        repeat (25) @(posedge clk);
        #1;
        drive_one(-45, -8, a);
        wait_out(a, "after_clear");
        drain("clear");

        // Reset while the output is valid and stalled.
        for (int i = 0; i < 20; i++) begin
            drive_one(30 * i - 300, ref_avg(30 * i - 300), a);
        end
        rdy_force = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_idle("after_reset", 1'b1);
        rdy_force = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        drive_one(57, 10, a);
        wait_out(a, "after_reset");
        drain("reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
